// File: rtl/pipelined_dp_ram_pkg.sv
// rtl/pipelined_dp_ram_pkg.sv - shared types and helpers for pipelined_dp_ram
package pipelined_dp_ram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ctrl_state_e;

  // One byte lane of a byte-enabled update: enabled lanes take the new byte.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       en);
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/pipelined_dp_ram_rd_pipe_stage.sv
// rtl/pipelined_dp_ram_rd_pipe_stage.sv - per-port read valid/data delay line
// Data registers only load on a valid beat so the output holds between reads.
module rd_pipe_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign valid_out = valid_in;
    assign data_out  = data_in;
  end else begin : g_delay
    logic [STAGES-1:0]     valid_q;
    logic [DATA_WIDTH-1:0] data_q [STAGES];

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= '0;
        for (int s = 0; s < STAGES; s++) begin
          data_q[s] <= '0;
        end
      end else begin
        valid_q[0] <= valid_in;
        if (valid_in) begin
          data_q[0] <= data_in;
        end
        for (int s = 1; s < STAGES; s++) begin
          valid_q[s] <= valid_q[s-1];
          if (valid_q[s-1]) begin
            data_q[s] <= data_q[s-1];
          end
        end
      end
    end

    assign valid_out = valid_q[STAGES-1];
    assign data_out  = data_q[STAGES-1];
  end

endmodule

// File: rtl/pipelined_dp_ram.sv
// rtl/pipelined_dp_ram.sv - byte-enabled RAM, one write port, N pipelined read ports
// Memory is zeroed word by word after reset before any request is accepted.
module pipelined_dp_ram
  import pipelined_dp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_DEPTH   = 1024,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int RD_LATENCY   = 1,
  parameter int WRITE_FIRST  = 1
) (
  input  logic                               Clk_CI,
  input  logic                               Rst_RI,
  input  logic                               WrEn_SI,
  input  logic [ADDR_WIDTH-1:0]              WrAddr_DI,
  input  logic [DATA_WIDTH-1:0]              WrData_DI,
  input  logic [DATA_WIDTH/8-1:0]            WrBe_DI,
  input  logic [NUM_RD_PORTS-1:0]            RdEn_SI,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] RdAddr_DI,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] RdData_DO,
  output logic [NUM_RD_PORTS-1:0]            RdValid_SO,
  output logic                               Ready_SO
);

  localparam int IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DATA_DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DATA_DEPTH - 1);
  localparam bit FWD_NEW = (WRITE_FIRST != 0);

  if (DATA_DEPTH < 2 || DATA_DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
    $error("pipelined_dp_ram: DATA_DEPTH out of range");
  end
  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("pipelined_dp_ram: DATA_WIDTH must be a positive multiple of 8");
  end
  if (NUM_RD_PORTS < 1 || NUM_RD_PORTS > 4) begin : g_bad_ports
    $error("pipelined_dp_ram: NUM_RD_PORTS out of range");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
    $error("pipelined_dp_ram: RD_LATENCY out of range");
  end

  ctrl_state_e      state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             clr_en;
  logic             ready;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_en    = 1'b0;
    ready     = 1'b0;
    case (state_q)
      INIT: begin
        clr_en = 1'b1;
        if (clr_cnt_q == LAST_IDX) begin
          state_d = READY;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      READY: begin
        ready = 1'b1;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  assign Ready_SO = ready;

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_in_range;
  logic                  wr_hit;

  assign wr_idx      = WrAddr_DI[IDX_W-1:0];
  assign wr_in_range = {1'b0, WrAddr_DI} < DEPTH_L;
  assign wr_hit      = ready && !Rst_RI && WrEn_SI && wr_in_range;

  // No reset on the array itself: the INIT sweep is what guarantees zeros.
  always_ff @(posedge Clk_CI) begin
    if (clr_en && !Rst_RI) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_hit) begin
      for (int b = 0; b < BE_W; b++) begin
        if (WrBe_DI[b]) begin
          mem[wr_idx][b*8 +: 8] <= WrData_DI[b*8 +: 8];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_port
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_in_range;
    logic                  rd_hit;
    logic                  collide;
    logic [DATA_WIDTH-1:0] mem_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  valid0_q;
    logic [DATA_WIDTH-1:0] data0_q;

    assign rd_addr     = RdAddr_DI[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_idx      = rd_addr[IDX_W-1:0];
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;
    assign rd_hit      = ready && RdEn_SI[p];
    assign collide     = FWD_NEW && wr_hit && (WrAddr_DI == rd_addr);
    assign mem_word    = mem[rd_idx];

    // Out-of-range reads still produce a valid beat, carrying zero.
    always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
        for (int b = 0; b < BE_W; b++) begin
          rd_word[b*8 +: 8] = merge_byte(mem_word[b*8 +: 8], WrData_DI[b*8 +: 8],
                                         collide && WrBe_DI[b]);
        end
      end
    end

    always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
        valid0_q <= 1'b0;
        data0_q  <= '0;
      end else begin
        valid0_q <= rd_hit;
        if (rd_hit) begin
          data0_q <= rd_word;
        end
      end
    end

    rd_pipe_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGES     (RD_LATENCY - 1)
    ) u_rd_pipe (
      .clk       (Clk_CI),
      .rst       (Rst_RI),
      .valid_in  (valid0_q),
      .data_in   (data0_q),
      .valid_out (RdValid_SO[p]),
      .data_out  (RdData_DO[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_pipelined_dp_ram.sv
// tb/tb_pipelined_dp_ram.sv - scoreboard bench for pipelined_dp_ram
// dut_a: latency 3, write-first; dut_b: latency 1, read-first; shared stimulus.
module tb_pipelined_dp_ram;

  localparam int DEPTH = 16;
  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  typedef struct packed {
    logic [31:0] due;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_valid_a, rd_valid_b;
  logic        ready_a, ready_b;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          since_rst = 0;
  logic        rst_q = 1'b0;
  logic        exp_ready;
  logic [31:0] mem_m [DEPTH];
  exp_t        q [4][$];
  logic [31:0] last [4];

  always #5 clk = ~clk;

  pipelined_dp_ram #(
    .ADDR_WIDTH(5), .DATA_DEPTH(DEPTH), .DATA_WIDTH(32),
    .NUM_RD_PORTS(2), .RD_LATENCY(LAT_A), .WRITE_FIRST(1)
  ) dut_a (
    .Clk_CI(clk), .Rst_RI(rst), .WrEn_SI(wr_en), .WrAddr_DI(wr_addr),
    .WrData_DI(wr_data), .WrBe_DI(wr_be), .RdEn_SI(rd_en), .RdAddr_DI(rd_addr),
    .RdData_DO(rd_data_a), .RdValid_SO(rd_valid_a), .Ready_SO(ready_a)
  );

  pipelined_dp_ram #(
    .ADDR_WIDTH(5), .DATA_DEPTH(DEPTH), .DATA_WIDTH(32),
    .NUM_RD_PORTS(2), .RD_LATENCY(LAT_B), .WRITE_FIRST(0)
  ) dut_b (
    .Clk_CI(clk), .Rst_RI(rst), .WrEn_SI(wr_en), .WrAddr_DI(wr_addr),
    .WrData_DI(wr_data), .WrBe_DI(wr_be), .RdEn_SI(rd_en), .RdAddr_DI(rd_addr),
    .RdData_DO(rd_data_b), .RdValid_SO(rd_valid_b), .Ready_SO(ready_b)
  );

  assign exp_ready = (since_rst >= DEPTH);

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
    if (rst) since_rst <= 0;
    else if (since_rst < 100000) since_rst <= since_rst + 1;
  end

  // Scoreboard: entries k = inst*2 + port, each due at an exact cycle.
  always @(negedge clk) begin
    logic [3:0]   v_all;
    logic [127:0] d_all;
    exp_t         e;
    v_all = {rd_valid_b, rd_valid_a};
    d_all = {rd_data_b, rd_data_a};
    if (rst_q) begin
      for (int k = 0; k < 4; k++) begin
        q[k].delete();
        last[k] = '0;
      end
    end
    n_cmp++;
    if (ready_a !== exp_ready || ready_b !== exp_ready) begin
      n_bad++;
      $display("FAIL ready cyc=%0d: got a=%b b=%b, expected %b", cyc, ready_a, ready_b, exp_ready);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (q[k].size() > 0 && q[k][0].due == cyc) begin
        e = q[k].pop_front();
        if (v_all[k] !== 1'b1 || d_all[k*32 +: 32] !== e.data) begin
          n_bad++;
          $display("FAIL read_beat k=%0d cyc=%0d: got valid=%b data=%h, expected valid=1 data=%h",
                   k, cyc, v_all[k], d_all[k*32 +: 32], e.data);
        end
        last[k] = e.data;
      end else if (v_all[k] !== 1'b0 || d_all[k*32 +: 32] !== last[k]) begin
        n_bad++;
        $display("FAIL idle_hold k=%0d cyc=%0d: got valid=%b data=%h, expected valid=0 data=%h",
                 k, cyc, v_all[k], d_all[k*32 +: 32], last[k]);
      end
    end
  end

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic [1:0] re,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    logic        acc;
    logic [4:0]  ra;
    logic [31:0] old_w, new_w;
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = {ra1, ra0};
    acc = exp_ready && !rst;
    for (int p = 0; p < 2; p++) begin
      if (acc && re[p]) begin
        ra = (p == 0) ? ra0 : ra1;
        old_w = (ra < DEPTH) ? mem_m[ra[3:0]] : 32'h0;
        new_w = old_w;
        if (we && ra < DEPTH && wa == ra)
          for (int b = 0; b < 4; b++) if (be[b]) new_w[b*8 +: 8] = wd[b*8 +: 8];
        q[p].push_back('{due: 32'(cyc + LAT_A), data: new_w});
        q[2 + p].push_back('{due: 32'(cyc + LAT_B), data: old_w});
      end
    end
    if (acc && we && wa < DEPTH)
      for (int b = 0; b < 4; b++) if (be[b]) mem_m[wa[3:0]][b*8 +: 8] = wd[b*8 +: 8];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 2'b00, '0, '0);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    wr_en = 1'b0; rd_en = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    for (int i = 1; i < n; i++) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts cycles from reset release to Ready; pokes a write+read into INIT.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready_a !== 1'b1 && n < 100) begin
      if (n == 4) drive(1'b1, 5'd2, 32'hCAFEF00D, 4'hF, 2'b11, 5'd2, 5'd2);
      else idle(1);
      n++;
    end
    n_cmp++;
    if (n !== DEPTH) begin
      n_bad++;
      $display("FAIL %s init_cycles: got %0d, expected %0d", name, n, DEPTH);
    end
  endtask

  task automatic test_reset();
    apply_reset(3);
    wait_ready("test_reset");
  endtask

  task automatic test_clear();
    for (int a = 0; a < DEPTH; a++) drive(1'b0, '0, '0, '0, 2'b11, 5'(a), 5'(DEPTH - 1 - a));
    idle(4);
  endtask

  task automatic test_byte_enable();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 4'b0101, 2'b00, '0, '0);
    drive(1'b1, 5'd5, 32'hFFFFFFFF, 4'b0000, 2'b00, '0, '0);
    drive(1'b0, '0, '0, '0, 2'b11, 5'd5, 5'd5);
    idle(4);
  endtask

  task automatic test_collision();
    drive(1'b1, 5'd3, 32'hAAAAAAAA, 4'hF, 2'b00, '0, '0);
    idle(1);
    drive(1'b1, 5'd3, 32'h12345678, 4'hF, 2'b11, 5'd3, 5'd3);
    drive(1'b1, 5'd3, 32'h55667788, 4'b0011, 2'b11, 5'd3, 5'd3);
    drive(1'b0, '0, '0, '0, 2'b11, 5'd3, 5'd3);
    idle(4);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) drive(1'b1, 5'(i), 32'h1000_0000 + 32'(i * 4369), 4'hF, 2'b00, '0, '0);
    for (int i = 0; i < 8; i++) drive(1'b0, '0, '0, '0, 2'b11, 5'(i), 5'(7 - i));
    idle(5);
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 5'd4, 32'h44444444, 4'hF, 2'b00, '0, '0);
    drive(1'b1, 5'd20, 32'hBADBAD00, 4'hF, 2'b11, 5'd20, 5'd4);
    drive(1'b0, '0, '0, '0, 2'b11, 5'd4, 5'd31);
    idle(4);
  endtask

  task automatic test_reset_in_flight();
    drive(1'b0, '0, '0, '0, 2'b11, 5'd0, 5'd1);
    drive(1'b0, '0, '0, '0, 2'b11, 5'd1, 5'd0);
    apply_reset(1);
    idle(8);
    apply_reset(1);
    wait_ready("test_reset_in_flight");
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++)
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), $urandom,
            4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 19)), 5'($urandom_range(0, 19)));
    idle(6);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    test_reset();
    test_clear();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_reset_in_flight();
    test_clear();
    test_random();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (q[k].size() !== 0) begin
        n_bad++;
        $display("FAIL drain k=%0d: got %0d pending reads, expected 0", k, q[k].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
